// File: rtl/ecc_pkg.sv
// rtl/ecc_pkg.sv - shared FSM state type, widths and defaults for the ECC receive unpacker
package ecc_pkg;

  // Width of one point coordinate (x or y) and of one plaintext byte
  localparam int PT_W            = 8;
  localparam int BYTE_W          = 8;
  // One beat carries two points, i.e. four coordinates
  localparam int BEAT_W          = 4 * PT_W;
  // Default decrypt-core latency and the width of the latency down-counter (covers 1..7)
  localparam int DEC_LAT_DEFAULT = 2;
  localparam int LAT_W           = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE_LO,
    S_WAIT_LO,
    S_ISSUE_HI,
    S_WAIT_HI,
    S_DONE
  } rx_state_t;

  // Beat layout in the FIFO: {y2,x2} in the upper half, {y1,x1} in the lower half,
  // so each half is exactly the {y,x} word handed to one decrypt core.
  function automatic logic [BEAT_W-1:0] pack_beat(
    input logic [PT_W-1:0] x1,
    input logic [PT_W-1:0] y1,
    input logic [PT_W-1:0] x2,
    input logic [PT_W-1:0] y2
  );
    return {y2, x2, y1, x1};
  endfunction

endpackage

// File: rtl/ecc_rx_fifo.sv
// rtl/ecc_rx_fifo.sv - ciphertext beat buffer with push/pop/full/empty
module ecc_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_pop_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  // Head of queue is read combinationally so the pop cycle can register it directly
  assign o_pop_data = r_mem[r_rd_ptr];
  assign o_full     = (r_count == (AW+1)'(DEPTH));
  assign o_empty    = (r_count == '0);

  // Storage array; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; push and pop together keep occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ecc_rx_unpack.sv
// rtl/ecc_rx_unpack.sv - beat buffering, decrypt sequencing and word reassembly (ECC_RX_STATS_EN adds the word counter)
module ecc_rx_unpack
  import ecc_pkg::*;
#(
  parameter int DEC_LAT    = DEC_LAT_DEFAULT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                s0,
  input  logic [PT_W-1:0]     x_in1,
  input  logic [PT_W-1:0]     y_in1,
  input  logic [PT_W-1:0]     x_in2,
  input  logic [PT_W-1:0]     y_in2,
  output logic [2*PT_W-1:0]   dec_in0,
  output logic [2*PT_W-1:0]   dec_in1,
  input  logic [BYTE_W-1:0]   dec_out0,
  input  logic [BYTE_W-1:0]   dec_out1,
  output logic [4*BYTE_W-1:0] data_out,
  output logic                data_valid,
  output logic                fifo_full,
  output logic                overflow,
  output logic [15:0]         rx_word_cnt
);

  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic              w_push;
  logic              w_pop;
  logic [BEAT_W-1:0] w_beat;
  logic [BEAT_W-1:0] w_head;
  logic              w_cap_lo;
  logic              w_cap_hi;
  logic              w_done;
  logic              w_lat_zero;

  rx_state_t         r_state;
  rx_state_t         w_next;

  logic [LAT_W-1:0]    r_lat_cnt;
  logic [2*PT_W-1:0]   r_dec_in0;
  logic [2*PT_W-1:0]   r_dec_in1;
  logic [4*BYTE_W-1:0] r_word;
  logic [4*BYTE_W-1:0] r_data_out;
  logic                r_data_valid;
  logic                r_overflow;

  assign w_beat     = pack_beat(x_in1, y_in1, x_in2, y_in2);
  // A beat arriving at full still fits when the FSM frees a slot in the same cycle
  assign w_push     = s0 && (!w_fifo_full || w_pop);
  assign w_lat_zero = (r_lat_cnt == '0);

  ecc_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (BEAT_W)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_data (w_beat),
    .i_pop       (w_pop),
    .o_pop_data  (w_head),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and per-state strobes: low half first, high half second, then one DONE cycle
  always_comb begin
    w_next   = r_state;
    w_pop    = 1'b0;
    w_cap_lo = 1'b0;
    w_cap_hi = 1'b0;
    w_done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_fifo_empty) w_next = S_ISSUE_LO;
      end
      S_ISSUE_LO: begin
        if (!w_fifo_empty) begin
          w_pop  = 1'b1;
          w_next = S_WAIT_LO;
        end
      end
      S_WAIT_LO: begin
        if (w_lat_zero) begin
          w_cap_lo = 1'b1;
          w_next   = S_ISSUE_HI;
        end
      end
      S_ISSUE_HI: begin
        if (!w_fifo_empty) begin
          w_pop  = 1'b1;
          w_next = S_WAIT_HI;
        end
      end
      S_WAIT_HI: begin
        if (w_lat_zero) begin
          w_cap_hi = 1'b1;
          w_next   = S_DONE;
        end
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Decrypt-core drive, latency countdown and half-word staging; data_out only changes on DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dec_in0    <= '0;
      r_dec_in1    <= '0;
      r_lat_cnt    <= '0;
      r_word       <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
    end else begin
      if (w_pop) begin
        r_dec_in0 <= w_head[2*PT_W-1:0];
        r_dec_in1 <= w_head[4*PT_W-1:2*PT_W];
        r_lat_cnt <= LAT_W'(DEC_LAT - 1);
      end else if (!w_lat_zero) begin
        r_lat_cnt <= r_lat_cnt - LAT_W'(1);
      end
      if (w_cap_lo) begin
        r_word[2*BYTE_W-1:0] <= {dec_out1, dec_out0};
      end
      if (w_cap_hi) begin
        r_word[4*BYTE_W-1:2*BYTE_W] <= {dec_out1, dec_out0};
      end
      if (w_done) begin
        r_data_out <= r_word;
      end
      r_data_valid <= w_done;
    end
  end

  // Sticky drop flag: a beat offered at full with no slot freed this cycle is lost
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (s0 && w_fifo_full && !w_pop) begin
      r_overflow <= 1'b1;
    end
  end

`ifdef ECC_RX_STATS_EN
  logic [15:0] r_rx_word_cnt;

  // Delivered-word counter, advancing together with data_valid and holding at all-ones
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_word_cnt <= '0;
    end else if (w_done && (r_rx_word_cnt != 16'hFFFF)) begin
      r_rx_word_cnt <= r_rx_word_cnt + 16'd1;
    end
  end

  assign rx_word_cnt = r_rx_word_cnt;
`else
  assign rx_word_cnt = '0;
`endif

  assign dec_in0    = r_dec_in0;
  assign dec_in1    = r_dec_in1;
  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign fifo_full  = w_fifo_full;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_ecc_rx_unpack.sv
// tb/tb_ecc_rx_unpack.sv - directed self-checking bench for ecc_rx_unpack
module tb_ecc_rx_unpack;

  localparam int DEC_LAT    = 4;
  localparam int FIFO_DEPTH = 8;
`ifdef ECC_RX_STATS_EN
  localparam logic [15:0] EXP_CNT5 = 16'd5;
`else
  localparam logic [15:0] EXP_CNT5 = 16'd0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        s0;
  logic [7:0]  x_in1, y_in1, x_in2, y_in2;
  logic [15:0] dec_in0, dec_in1;
  logic [7:0]  dec_out0, dec_out1;
  logic [31:0] data_out;
  logic        data_valid;
  logic        fifo_full;
  logic        overflow;
  logic [15:0] rx_word_cnt;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          n_valid  = 0;
  logic [31:0] words[$];

  // Decrypt-core model: byte = x ^ A5, result valid DEC_LAT edges after dec_in is driven
  logic [7:0]  r_p0 [DEC_LAT-1];
  logic [7:0]  r_p1 [DEC_LAT-1];

  always #5 clk = ~clk;

  ecc_rx_unpack #(
    .DEC_LAT    (DEC_LAT),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .s0          (s0),
    .x_in1       (x_in1),
    .y_in1       (y_in1),
    .x_in2       (x_in2),
    .y_in2       (y_in2),
    .dec_in0     (dec_in0),
    .dec_in1     (dec_in1),
    .dec_out0    (dec_out0),
    .dec_out1    (dec_out1),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .fifo_full   (fifo_full),
    .overflow    (overflow),
    .rx_word_cnt (rx_word_cnt)
  );

  always @(posedge clk) begin
    r_p0[0] <= dec_in0[7:0] ^ 8'hA5;
    r_p1[0] <= dec_in1[7:0] ^ 8'hA5;
    for (int i = 1; i < DEC_LAT - 1; i++) begin
      r_p0[i] <= r_p0[i-1];
      r_p1[i] <= r_p1[i-1];
    end
  end
  assign dec_out0 = r_p0[DEC_LAT-2];
  assign dec_out1 = r_p1[DEC_LAT-2];

  // Collect delivered words away from the active edge
  always @(negedge clk) begin
    if (data_valid === 1'b1) begin
      words.push_back(data_out);
      n_valid++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [7:0] a1, input logic [7:0] b1,
                      input logic [7:0] a2, input logic [7:0] b2);
    s0 = 1'b1; x_in1 = a1; y_in1 = b1; x_in2 = a2; y_in2 = b2;
    tick();
    s0 = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    words.delete();
  endtask

  task automatic wait_words(input string tag, input int n, input int budget);
    int c = 0;
    while (words.size() < n && c < budget) begin
      tick();
      c++;
    end
    chk(tag, 32'(words.size()), 32'(n));
  endtask

  // Expected word from the x bytes of the low beat (a) and the high beat (b)
  function automatic logic [31:0] wexp(input logic [7:0] a1, input logic [7:0] a2,
                                       input logic [7:0] b1, input logic [7:0] b2);
    return {b2 ^ 8'hA5, b1 ^ 8'hA5, a2 ^ 8'hA5, a1 ^ 8'hA5};
  endfunction

  initial begin
    int          lat;
    int          v0;
    logic [7:0]  seq [11];

    reset = 1'b1; s0 = 1'b0;
    x_in1 = '0; y_in1 = '0; x_in2 = '0; y_in2 = '0;
    tick();
    tick();

    // Reset state
    chk("rst_data_out",   data_out,          32'h0);
    chk("rst_data_valid", 32'(data_valid),   32'h0);
    chk("rst_dec_in0",    32'(dec_in0),      32'h0);
    chk("rst_dec_in1",    32'(dec_in1),      32'h0);
    chk("rst_fifo_full",  32'(fifo_full),    32'h0);
    chk("rst_overflow",   32'(overflow),     32'h0);
    chk("rst_word_cnt",   32'(rx_word_cnt),  32'h0);
    reset = 1'b0;
    tick();

    // Reference word from two beats
    beat(8'h11, 8'h5A, 8'h22, 8'h6B);
    beat(8'h33, 8'h7C, 8'h44, 8'h8D);
    wait_words("ref_count", 1, 60);
    if (words.size() >= 1) chk("ref_word", words[0], 32'hE196_87B4);

    // Lone beat parks in ISSUE_HI; second beat completes the word with minimum latency
    words.delete();
    v0 = n_valid;
    beat(8'h3C, 8'h01, 8'hC3, 8'h02);
    repeat (20) tick();
    chk("park_no_valid", 32'(n_valid), 32'(v0));
    chk("park_dec_in0",  32'(dec_in0), 32'h013C);
    chk("park_dec_in1",  32'(dec_in1), 32'h02C3);
    beat(8'h5E, 8'h03, 8'hE5, 8'h04);
    lat = 1;
    while (data_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    chk("latency",      32'(lat),        32'(DEC_LAT + 3));
    chk("latency_word", data_out,        wexp(8'h3C, 8'hC3, 8'h5E, 8'hE5));
    tick();
    chk("valid_pulse",  32'(data_valid), 32'h0);
    chk("data_hold",    data_out,        wexp(8'h3C, 8'hC3, 8'h5E, 8'hE5));

    // Ten back-to-back beats -> five words in order, no drop
    do_reset();
    for (int i = 0; i < 10; i++) begin
      beat(8'(8'h10 + i), 8'(8'h20 + i), 8'(8'h80 + i), 8'(8'h90 + i));
    end
    wait_words("b2b_count", 5, 200);
    repeat (20) tick();
    chk("b2b_count_final", 32'(words.size()), 32'd5);
    for (int k = 0; k < 5 && k < words.size(); k++) begin
      chk($sformatf("b2b_word%0d", k), words[k],
          wexp(8'(8'h10 + 2*k), 8'(8'h80 + 2*k), 8'(8'h11 + 2*k), 8'(8'h81 + 2*k)));
    end
    chk("b2b_overflow", 32'(overflow),    32'h0);
    chk("b2b_word_cnt", 32'(rx_word_cnt), 32'(EXP_CNT5));

    // Push and pop together while full: occupancy holds, nothing dropped
    do_reset();
    beat(8'h01, 8'h00, 8'h81, 8'h00);
    tick();
    tick();
    for (int i = 0; i < 9; i++) begin
      beat(8'(8'h50 + i), 8'h00, 8'(8'hD0 + i), 8'h00);
    end
    tick();
    chk("pp_full_before", 32'(fifo_full), 32'h1);
    chk("pp_ovf_before",  32'(overflow),  32'h0);
    tick();
    beat(8'h5F, 8'h00, 8'hDF, 8'h00);
    chk("pp_full_after",  32'(fifo_full), 32'h1);
    chk("pp_ovf_after",   32'(overflow),  32'h0);
    chk("pp_words",       32'(words.size()), 32'd1);
    if (words.size() >= 1) chk("pp_word0", words[0], wexp(8'h01, 8'h81, 8'h50, 8'hD0));

    // Flood during WAIT_LO: FIFO fills, the surplus beat is dropped and never delivered
    do_reset();
    seq[0] = 8'h3F;
    for (int j = 0; j < 10; j++) seq[j+1] = 8'(8'h40 + j);
    beat(seq[0], 8'h00, seq[0] ^ 8'h80, 8'h00);
    tick();
    tick();
    for (int j = 1; j <= FIFO_DEPTH + 2; j++) begin
      beat(seq[j], 8'h00, seq[j] ^ 8'h80, 8'h00);
    end
    chk("flood_full",     32'(fifo_full), 32'h1);
    chk("flood_overflow", 32'(overflow),  32'h1);
    wait_words("flood_count", 5, 300);
    repeat (30) tick();
    chk("flood_count_final", 32'(words.size()), 32'd5);
    for (int k = 0; k < 5 && k < words.size(); k++) begin
      chk($sformatf("flood_word%0d", k), words[k],
          wexp(seq[2*k], seq[2*k] ^ 8'h80, seq[2*k+1], seq[2*k+1] ^ 8'h80));
    end
    chk("flood_ovf_sticky", 32'(overflow), 32'h1);

    // Reset during WAIT_HI discards the partial word
    words.delete();
    beat(8'h61, 8'h11, 8'hE1, 8'h22);
    beat(8'h62, 8'h33, 8'hE2, 8'h44);
    repeat (7) tick();
    v0 = n_valid;
    reset = 1'b1;
    tick();
    chk("mid_data_out",   data_out,         32'h0);
    chk("mid_data_valid", 32'(data_valid),  32'h0);
    chk("mid_dec_in0",    32'(dec_in0),     32'h0);
    chk("mid_dec_in1",    32'(dec_in1),     32'h0);
    chk("mid_fifo_full",  32'(fifo_full),   32'h0);
    chk("mid_overflow",   32'(overflow),    32'h0);
    chk("mid_word_cnt",   32'(rx_word_cnt), 32'h0);
    reset = 1'b0;
    repeat (20) tick();
    chk("mid_no_valid",   32'(n_valid), 32'(v0));
    words.delete();
    beat(8'h71, 8'h55, 8'hF1, 8'h66);
    beat(8'h72, 8'h77, 8'hF2, 8'h88);
    wait_words("fresh_count", 1, 60);
    if (words.size() >= 1) chk("fresh_word", words[0], wexp(8'h71, 8'hF1, 8'h72, 8'hF2));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
